pc_target_lut: RTL and testbench
================================

PC_TARGET_LUT -- requirements
Module: pc_target_lut

Interface
REQ-001 Parameter D, default 12: PC and target width in bits.
REQ-002 Parameter N, default 8: number of target-table entries; SHALL be a power of 2 and at least 2.
REQ-003 Parameter IW, default $clog2(N): table index width.
REQ-004 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  when 1, hold the PC.
REQ-007 branch_en  input  1  take the table target this cycle.
REQ-008 how_high  input  IW  table index used when branch_en=1.
REQ-009 wr_en  input  1  table write strobe.
REQ-010 wr_idx  input  IW  table index to write.
REQ-011 wr_data  input  D  target value to write.
REQ-012 wr_abs  input  1  mode of the written entry: 1 = absolute, 0 = relative offset.
REQ-013 pc  output  D  current program counter.
REQ-014 ready  output  1  1 when the table is initialised and the PC is running.
REQ-015 target  output  D  combinational table value at how_high, for debug.

Function
REQ-016 The FSM SHALL have two states:
  - INIT: entered on reset.
  - RUN: entered after the last INIT write; RUN is terminal until reset.
REQ-017 INIT SHALL write one entry per cycle, index 0 to N-1, with mode relative and default values:
  - even i: +2^(i/2+1)
  - odd i: -2^((i-1)/2+1)
  - all values two's complement mod 2^D (N=8 gives 2,-2,4,-4,8,-8,16,-16).
REQ-018 INIT SHALL last exactly N cycles after reset release, then enter RUN; ready SHALL rise on the first RUN cycle.
REQ-019 In INIT:
  - pc SHALL hold 0;
  - stall, branch_en and wr_en SHALL be ignored.
REQ-020 In RUN with stall=1, pc SHALL hold and branch_en SHALL be ignored.
REQ-021 In RUN with stall=0 and branch_en=0, pc SHALL become pc+1 mod 2^D.
REQ-022 In RUN with stall=0 and branch_en=1, pc SHALL become:
  - pc + entry[how_high] mod 2^D if the entry is relative;
  - entry[how_high] if the entry is absolute.
REQ-023 Wrap-around SHALL be silent, with no flag (D=12: pc 4095 +1 -> 0; pc 3 + (-5) -> 4094).
REQ-024 In RUN, wr_en=1 SHALL update value and mode of entry[wr_idx] at the clock edge; writes are independent of stall.
REQ-025 A write and a branch to the same index in the same cycle SHALL use the old entry; the new entry is visible from the next cycle.
REQ-026 target SHALL equal the value field of entry[how_high] in every state; it is undefined only for entries not yet initialised during INIT.
REQ-027 Latency: the branch decision in cycle t SHALL appear on pc in cycle t+1; there are no bubbles.

Reset
REQ-028 Reset_n=0 SHALL asynchronously:
  - set pc=0 and ready=0;
  - set the FSM to INIT;
  - set the init counter to 0.
REQ-029 Table contents SHALL NOT be reset directly; INIT rewrites every entry after each reset.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from index 0 and discard all programmed entries.

Verification
REQ-031 Release reset, idle inputs, N=8 -> ready=0 for 8 cycles, then 1; pc=0 through INIT, then 1,2,3...
REQ-032 RUN at pc=10, branch_en=1, how_high=5 -> pc=2; then how_high=6 -> pc=18.
REQ-033 Write idx 3 value 100 abs=1, next cycle branch idx 3 -> pc=100; same-cycle write+branch to idx 3 -> old offset -4 applied.
REQ-034 pc=4095, no branch -> pc=0; pc=1, branch idx 1 (-2) -> pc=4095.
REQ-035 stall=1 with branch_en=1 for 3 cycles -> pc unchanged; deassert -> branch taken next edge.
REQ-036 Program idx 0 to abs 50, assert Reset_n=0 mid-RUN asynchronously -> pc=0 immediately; after INIT, branch idx 0 -> pc+2.

Source files
------------

// File: rtl/pc_target_lut.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_lut
// Description : Program counter with a programmable branch-target table.
//               The table is self-initialised after reset, then the PC runs.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_lut #(
    parameter int D  = 12,
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          stall,
    input  logic          branch_en,
    input  logic [IW-1:0] how_high,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [D-1:0]  wr_data,
    input  logic          wr_abs,
    output logic [D-1:0]  pc,
    output logic          ready,
    output logic [D-1:0]  target
);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [D-1:0]  c_one     = {{(D-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] c_cnt_one = IW'(1);
    localparam logic [IW-1:0] c_cnt_end = IW'(N - 1);

    state_t        r_state;
    logic [IW-1:0] r_cnt;
    logic [D-1:0]  r_pc;
    logic          r_ready;

    // Table storage is never reset; INIT rewrites every entry instead.
    logic [D-1:0]  r_val [N];
    logic [N-1:0]  r_abs;

    logic [IW:0]   w_shamt;
    logic [D-1:0]  w_mag;
    logic [D-1:0]  w_init_val;
    logic [D-1:0]  w_entry;
    logic [D-1:0]  w_next_pc;

    // Default entry i: +2^(i/2+1) for even i, its negation for odd i.
    always_comb begin
        w_shamt    = {1'b0, (r_cnt >> 1)} + {{IW{1'b0}}, 1'b1};
        w_mag      = c_one << w_shamt;
        w_init_val = r_cnt[0] ? (~w_mag + c_one) : w_mag;
    end

    always_comb begin
        w_entry   = r_val[how_high];
        w_next_pc = r_pc;
        if (!stall) begin
            if (branch_en) begin
                w_next_pc = r_abs[how_high] ? w_entry : (r_pc + w_entry);
            end else begin
                w_next_pc = r_pc + c_one;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_cnt <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_end) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_pc <= w_next_pc;
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    // Registered table: a same-cycle write and branch to one index sees the old entry.
    always_ff @(posedge Clk) begin
        if (r_state == S_INIT) begin
            r_val[r_cnt] <= w_init_val;
            r_abs[r_cnt] <= 1'b0;
        end else if (wr_en) begin
            r_val[wr_idx] <= wr_data;
            r_abs[wr_idx] <= wr_abs;
        end
    end

    assign pc     = r_pc;
    assign ready  = r_ready;
    assign target = w_entry;

endmodule
`default_nettype wire

// File: tb/tb_pc_target_lut.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_target_lut
// Description : Self-checking bench for pc_target_lut against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_target_lut;

    localparam int D    = 12;
    localparam int N    = 8;
    localparam int IW   = 3;
    localparam int MASK = (1 << D) - 1;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          stall = 1'b0;
    logic          branch_en = 1'b0;
    logic [IW-1:0] how_high = '0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [D-1:0]  wr_data = '0;
    logic          wr_abs = 1'b0;
    logic [D-1:0]  pc;
    logic          ready;
    logic [D-1:0]  target;

    pc_target_lut #(.D(D), .N(N), .IW(IW)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .stall     (stall),
        .branch_en (branch_en),
        .how_high  (how_high),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .wr_abs    (wr_abs),
        .pc        (pc),
        .ready     (ready),
        .target    (target)
    );

    always #5 Clk = ~Clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: table as plain arrays, PC as an integer.
    int m_val [N];
    bit m_abs [N];
    int m_pc;
    bit m_ready;
    int m_cnt;

    function automatic int def_val(int i);
        int mag;
        mag = 1 << (i / 2 + 1);
        return ((i % 2) != 0 ? -mag : mag) & MASK;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_ready = 0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        int nxt;
        if (!Reset_n) begin
            model_reset();
        end else if (!m_ready) begin
            m_val[m_cnt] = def_val(m_cnt);
            m_abs[m_cnt] = 0;
            m_cnt++;
            if (m_cnt == N) m_ready = 1;
        end else begin
            nxt = m_pc;
            if (!stall) begin
                if (branch_en)
                    nxt = m_abs[how_high] ? m_val[how_high] : (m_pc + m_val[how_high]) & MASK;
                else
                    nxt = (m_pc + 1) & MASK;
            end
            if (wr_en) begin
                m_val[wr_idx] = int'(wr_data);
                m_abs[wr_idx] = wr_abs;
            end
            m_pc = nxt;
        end
    endtask

    task automatic compare();
        chk("pc", int'(pc), m_pc);
        chk("ready", int'(ready), int'(m_ready));
        if (int'(how_high) < m_cnt)
            chk("target", int'(target), m_val[how_high]);
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        compare();
    endtask

    task automatic idle();
        stall = 0; branch_en = 0; wr_en = 0; wr_abs = 0;
        how_high = '0; wr_idx = '0; wr_data = '0;
    endtask

    task automatic rand_inputs();
        stall     = ($urandom_range(0, 3) == 0);
        branch_en = ($urandom_range(0, 9) < 3);
        how_high  = IW'($urandom_range(0, N - 1));
        wr_en     = ($urandom_range(0, 4) == 0);
        wr_idx    = IW'($urandom_range(0, N - 1));
        wr_data   = D'($urandom);
        wr_abs    = $urandom_range(0, 1) == 1;
    endtask

    task automatic branch_to(int idx);
        idle();
        branch_en = 1;
        how_high  = IW'(idx);
    endtask

    initial begin
        model_reset();
        idle();
        cycle();
        cycle();
        chk("reset_pc", int'(pc), 0);
        chk("reset_ready", int'(ready), 0);

        // Release with idle inputs: ready low through INIT, then the PC counts.
        Reset_n = 1;
        for (int i = 0; i < N - 1; i++) begin
            cycle();
            chk("init_ready_low", int'(ready), 0);
        end
        cycle();
        chk("first_run_ready", int'(ready), 1);
        chk("first_run_pc", int'(pc), 0);
        chk("init_target0", int'(target), 2);
        cycle();
        chk("count_pc1", int'(pc), 1);
        while (m_pc != 10) cycle();

        branch_to(5);
        cycle();
        chk("branch_idx5", int'(pc), 2);
        branch_to(6);
        cycle();
        chk("branch_idx6", int'(pc), 18);

        // Same-cycle write+branch uses the old relative -4; next branch sees abs 100.
        branch_to(3);
        wr_en = 1; wr_idx = 3; wr_data = 100; wr_abs = 1;
        cycle();
        chk("wr_br_same_cycle", int'(pc), 14);
        branch_to(3);
        cycle();
        chk("branch_abs100", int'(pc), 100);

        // Wrap-around in both directions.
        branch_to(0);
        wr_en = 1; wr_idx = 0; wr_data = D'(4095); wr_abs = 1;
        cycle();
        branch_to(0);
        cycle();
        chk("pc_4095", int'(pc), 4095);
        idle();
        cycle();
        chk("wrap_inc", int'(pc), 0);
        cycle();
        branch_to(1);
        cycle();
        chk("wrap_neg", int'(pc), 4095);

        // Stall holds the PC and blocks the branch; release takes it.
        branch_to(2);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_hold", int'(pc), 4095);
        end
        stall = 0;
        cycle();
        chk("stall_release_branch", int'(pc), 3);

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            cycle();
        end

        // Asynchronous reset mid-RUN discards programmed entries.
        idle();
        wr_en = 1; wr_idx = 0; wr_data = 50; wr_abs = 1;
        cycle();
        idle();
        #2 Reset_n = 0;
        #1;
        chk("async_rst_pc", int'(pc), 0);
        chk("async_rst_ready", int'(ready), 0);
        model_reset();
        cycle();
        Reset_n = 1;
        for (int i = 0; i < N; i++) begin
            rand_inputs();
            cycle();
        end
        chk("post_rst_pc", int'(pc), 0);
        branch_to(0);
        cycle();
        chk("post_rst_branch0", int'(pc), 2);

        for (int i = 0; i < 150; i++) begin
            rand_inputs();
            cycle();
        end

        // Reset in the middle of INIT restarts the sequence from index 0.
        idle();
        Reset_n = 0;
        #1;
        model_reset();
        cycle();
        Reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cycle();
        end
        Reset_n = 0;
        #1;
        chk("mid_init_rst_pc", int'(pc), 0);
        model_reset();
        cycle();
        Reset_n = 1;
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
